pc_next_sel: RTL and testbench
==============================

PC_NEXT_SEL -- requirements
Module: pc_next_sel

Interface
REQ-001 SHALL have parameter: WIDTH, 32, PC/address width in bits.
REQ-002 SHALL have parameter: NSRC, 4, number of redirect sources (2..8).
REQ-003 SHALL have parameter: RESET_VEC, 32'h0040_0000, PC value after reset.
REQ-004 SHALL have parameter: INC, 4, sequential PC increment.
REQ-005 SHALL have port: clk  input  1  single clock, rising edge; one clock only.
REQ-006 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: stall  input  1  hold PC this cycle.
REQ-008 SHALL have port: flush  input  1  discard pending redirect.
REQ-009 SHALL have port: src_req  input  NSRC  per-source redirect request.
REQ-010 SHALL have port: src_data  input  NSRC*WIDTH  targets; source i at bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port: pc  output  WIDTH  current fetch PC, registered.
REQ-012 SHALL have port: pc_valid  output  1  pc is valid for fetch.
REQ-013 SHALL have port: redirect  output  1  pc was loaded from a source or pending target on last edge.
REQ-014 SHALL have port: sel  output  clog2(NSRC)  index of source most recently loaded.
REQ-015 SHALL have port: pend  output  1  a redirect is held pending.
REQ-016 SHALL have port: misalign  output  1  sticky misaligned-target flag.

Function
REQ-017 SHALL resolve simultaneous src_req bits by fixed priority, lowest index highest.
REQ-018 SHALL, on the first edge after rst_n deasserts, set pc_valid=1, hold pc=RESET_VEC, and treat any src_req as if stall=1.
REQ-019 SHALL, on each later edge with stall=0, load pc by priority: winning live src_req target, else pending target, else pc+INC.
REQ-020 SHALL clear pend whenever pc loads from live request or pending target with stall=0.
REQ-021 SHALL hold pc on edges with stall=1; any src_req SHALL capture winning target and index into pending, overwriting older pending (latest wins).
REQ-022 SHALL give flush priority over capture: flush=1 clears pend and drops same-cycle src_req when stall=1; with stall=0, flush has no effect on pc loading.
REQ-023 SHALL compute pc+INC modulo 2^WIDTH (wrap, no carry out).
REQ-024 SHALL assert redirect for exactly one cycle after each source/pending load, 0 otherwise; sel updates only on such loads.
REQ-025 SHALL have single-edge latency: src_req sampled at edge N appears on pc after edge N.

Reset
REQ-026 SHALL, while rst_n=0 and immediately on assertion (no clock), force pc=RESET_VEC, pc_valid=0, redirect=0, sel=0, pend=0, misalign=0.
REQ-027 SHALL discard any pending redirect on reset mid-operation.

Configuration
REQ-028 SHALL use macro PC_ALIGN_CHECK_EN: when defined, misalign sets to 1 on any load whose target has bits [1:0]!=0 and stays 1 until reset; target is still loaded unchanged.
REQ-029 SHALL, when PC_ALIGN_CHECK_EN is undefined, tie misalign to 0 with no check logic.

Verification
REQ-030 SHALL cover: reset release, stall=0, no req -> pc 0x00400000 (valid) then 0x00400004, 0x00400008.
REQ-031 SHALL cover: src_req=4'b0110, src_data[1]=0x1000, [2]=0x2000 -> next pc=0x1000, sel=1, redirect=1 for one cycle, then pc=0x1004.
REQ-032 SHALL cover: stall=1 three cycles, src_req[3] one cycle with 0x80000180 -> pc held, pend=1; stall drops -> pc=0x80000180, pend=0.
REQ-033 SHALL cover: pending 0x3000 held, stall drops with src_req[0]=0x5000 same cycle -> pc=0x5000, pend=0; separately flush during stall -> pend=0, pc resumes +INC.
REQ-034 SHALL cover: load 0xFFFFFFFC -> next pc 0x00000000; rst_n low mid-run -> pc=0x00400000, pc_valid=0, pend=0 without clock.
REQ-035 SHALL cover (PC_ALIGN_CHECK_EN defined): load 0x1002 -> pc=0x1002, misalign=1, stays 1 after aligned loads until reset.

Source files
------------

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC select with priority redirects, stall-time pending capture; optional PC_ALIGN_CHECK_EN misalign flag
module pc_next_sel #(
  parameter int               WIDTH     = 32,
  parameter int               NSRC      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0040_0000,
  parameter int               INC       = 4,
  localparam int              SW        = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [NSRC-1:0]       src_req,
  input  logic [NSRC*WIDTH-1:0] src_data,
  output logic [WIDTH-1:0]      pc,
  output logic                  pc_valid,
  output logic                  redirect,
  output logic [SW-1:0]         sel,
  output logic                  pend,
  output logic                  misalign
);
  logic [WIDTH-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, win_pc, load_pc;
  logic [SW-1:0]    sel_q, sel_d, pend_sel_q, pend_sel_d, win_idx, load_sel;
  logic             pc_valid_q, redirect_q, redirect_d, pend_q, pend_d;
  logic             any_req, hold, load_src, load_pend, load, capture;
  // fixed-priority pick: lowest index wins, so scan downward and let later hits override
  always_comb begin
    win_idx = '0;
    win_pc  = '0;
    any_req = |src_req;
    for (int i = NSRC - 1; i >= 0; i--)
      if (src_req[i]) begin
        win_idx = SW'(i);
        win_pc  = src_data[i*WIDTH +: WIDTH];
      end
  end
  // first edge after reset behaves as a stall so requests land in the pending slot
  always_comb begin
    hold       = stall | ~pc_valid_q;
    load_src   = ~hold & any_req;
    load_pend  = ~hold & ~any_req & pend_q;
    load       = load_src | load_pend;
    load_pc    = load_src ? win_pc : pend_pc_q;
    load_sel   = load_src ? win_idx : pend_sel_q;
    capture    = hold & ~flush & any_req;
    pc_d       = hold ? pc_q : load ? load_pc : pc_q + WIDTH'(INC);
    redirect_d = load;
    sel_d      = load ? load_sel : sel_q;
    pend_d     = hold & ~flush & (any_req | pend_q);
    pend_pc_d  = capture ? win_pc : pend_pc_q;
    pend_sel_d = capture ? win_idx : pend_sel_q;
  end
  // state registers, async active-low reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      redirect_q <= 1'b0;
      sel_q      <= '0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      pend_sel_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
      redirect_q <= redirect_d;
      sel_q      <= sel_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      pend_sel_q <= pend_sel_d;
    end
`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  // sticky flag set by any redirect load with a non-word-aligned target
  always_comb misalign_d = misalign_q | (load & |load_pc[1:0]);
  // misalign register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misalign_q <= 1'b0;
    else misalign_q <= misalign_d;
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif
  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign redirect = redirect_q;
  assign sel      = sel_q;
  assign pend     = pend_q;
endmodule

// File: tb/tb_pc_next_sel.sv
// tb_pc_next_sel: directed vectors for pc_next_sel; set PC_ALIGN_CHECK_EN to check the misalign flag
module tb_pc_next_sel;
  logic         clk = 0, rst_n = 1, stall = 0, flush = 0;
  logic [3:0]   src_req = '0;
  logic [127:0] src_data = '0;
  logic [31:0]  pc;
  logic         pc_valid, redirect, pend, misalign;
  logic [1:0]   sel;
  int           n_vec = 0, n_bad = 0;
`ifdef PC_ALIGN_CHECK_EN
  localparam logic MIS_EXP = 1'b1;
`else
  localparam logic MIS_EXP = 1'b0;
`endif

  pc_next_sel dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .src_req(src_req), .src_data(src_data), .pc(pc), .pc_valid(pc_valid),
    .redirect(redirect), .sel(sel), .pend(pend), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic [31:0] v);
    src_req = 4'b0001 << i;
    src_data[i*32 +: 32] = v;
  endtask

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_valid", pc_valid, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_sel", sel, 0);
    chk("rst_pend", pend, 0);
    chk("rst_misalign", misalign, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    step();
    chk("first_pc", pc, 32'h0040_0000);
    chk("first_valid", pc_valid, 1);
    chk("first_redirect", redirect, 0);
    step();
    chk("seq_pc1", pc, 32'h0040_0004);
    step();
    chk("seq_pc2", pc, 32'h0040_0008);
    src_data[32 +: 32] = 32'h1000;
    src_data[64 +: 32] = 32'h2000;
    src_req = 4'b0110;
    step();
    chk("prio_pc", pc, 32'h1000);
    chk("prio_sel", sel, 1);
    chk("prio_redirect", redirect, 1);
    src_req = 0;
    step();
    chk("prio_next_pc", pc, 32'h1004);
    chk("prio_redirect_drop", redirect, 0);
    chk("prio_sel_hold", sel, 1);
    stall = 1;
    req(3, 32'h8000_0180);
    step();
    chk("stall_pc1", pc, 32'h1004);
    chk("stall_pend1", pend, 1);
    chk("stall_redirect", redirect, 0);
    src_req = 0;
    step();
    step();
    chk("stall_pc3", pc, 32'h1004);
    chk("stall_pend3", pend, 1);
    stall = 0;
    step();
    chk("pend_load_pc", pc, 32'h8000_0180);
    chk("pend_load_pend", pend, 0);
    chk("pend_load_sel", sel, 3);
    chk("pend_load_redirect", redirect, 1);
    stall = 1;
    req(1, 32'h3000);
    step();
    chk("pend3000_pend", pend, 1);
    chk("pend3000_sel", sel, 3);
    stall = 0;
    req(0, 32'h5000);
    step();
    chk("live_over_pend_pc", pc, 32'h5000);
    chk("live_over_pend_pend", pend, 0);
    chk("live_over_pend_sel", sel, 0);
    src_req = 0;
    step();
    chk("pend_discarded_pc", pc, 32'h5004);
    stall = 1;
    req(2, 32'h6000);
    step();
    chk("pre_flush_pend", pend, 1);
    src_req = 0;
    flush = 1;
    step();
    chk("flush_pend", pend, 0);
    chk("flush_pc", pc, 32'h5004);
    req(0, 32'h6100);
    step();
    chk("flush_drop_req", pend, 0);
    src_req = 0;
    flush = 0;
    stall = 0;
    step();
    chk("flush_resume_pc", pc, 32'h5008);
    chk("flush_resume_redirect", redirect, 0);
    flush = 1;
    req(0, 32'h7000);
    step();
    chk("flush_nostall_pc", pc, 32'h7000);
    chk("flush_nostall_redirect", redirect, 1);
    flush = 0;
    req(0, 32'hFFFF_FFFC);
    step();
    chk("wrap_load", pc, 32'hFFFF_FFFC);
    src_req = 0;
    step();
    chk("wrap_pc", pc, 32'h0);
    req(1, 32'h1002);
    step();
    chk("mis_pc", pc, 32'h1002);
    chk("mis_flag", misalign, MIS_EXP);
    src_req = 0;
    step();
    chk("mis_inc_pc", pc, 32'h1006);
    req(0, 32'h2000);
    step();
    chk("mis_sticky", misalign, MIS_EXP);
    stall = 1;
    req(1, 32'h1234);
    step();
    chk("pre_rst_pend", pend, 1);
    src_req = 0;
    stall = 0;
    #2 rst_n = 0;
    #1;
    chk("midrst_pc", pc, 32'h0040_0000);
    chk("midrst_valid", pc_valid, 0);
    chk("midrst_pend", pend, 0);
    chk("midrst_redirect", redirect, 0);
    chk("midrst_sel", sel, 0);
    chk("midrst_misalign", misalign, 0);
    #2 rst_n = 1;
    req(2, 32'hABC0);
    step();
    chk("rel_pc", pc, 32'h0040_0000);
    chk("rel_valid", pc_valid, 1);
    chk("rel_redirect", redirect, 0);
    chk("rel_pend", pend, 1);
    src_req = 0;
    step();
    chk("rel_pend_pc", pc, 32'hABC0);
    chk("rel_pend_sel", sel, 2);
    chk("rel_pend_redirect", redirect, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
